// File: rtl/sdio_txrx_seq_if.sv
// ---------------------------------------------------------------------------
// sdio_txrx_seq_if
//   Bundles the handshake between the transaction sequencer and the SDIO
//   command/data engines. Signal suffixes (_i/_o) are written from the
//   sequencer's point of view, so an _o signal is driven by the sequencer.
//
//   Command engine : cmd_start_o, cmd_op_o[5:0], cmd_arg_o[31:0],
//                    cmd_rsp_type_o[2:0] (seq -> engine);
//                    cmd_eot_i, cmd_err_i, start_read_i, start_write_i
//                    (engine -> seq)
//   Data engine    : data_start_o (seq -> engine);
//                    data_last_i, data_eot_i, data_err_i (engine -> seq)
//
//   master : sequencer side
//   slave  : engine side
// ---------------------------------------------------------------------------
interface sdio_txrx_seq_if;
  logic        cmd_start_o;
  logic [5:0]  cmd_op_o;
  logic [31:0] cmd_arg_o;
  logic [2:0]  cmd_rsp_type_o;
  logic        cmd_eot_i;
  logic        cmd_err_i;
  logic        start_read_i;
  logic        start_write_i;
  logic        data_start_o;
  logic        data_last_i;
  logic        data_eot_i;
  logic        data_err_i;

  modport master (
    output cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o, data_start_o,
    input  cmd_eot_i, cmd_err_i, start_read_i, start_write_i,
           data_last_i, data_eot_i, data_err_i
  );

  modport slave (
    input  cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o, data_start_o,
    output cmd_eot_i, cmd_err_i, start_read_i, start_write_i,
           data_last_i, data_eot_i, data_err_i
  );
endinterface

// File: rtl/sdio_txrx_seq.sv
// ---------------------------------------------------------------------------
// sdio_txrx_seq
//   Orders the command and data phases of one SDIO transfer. Multi-block
//   transfers terminate either through a pre-issued CMD23 (SET_BLOCK_COUNT)
//   or an automatic CMD12 (STOP) once the last block has started and the
//   main command has completed. A watchdog aborts stalled transfers. Each
//   transfer ends with a single eot_o pulse; results stay in sticky status.
//
//   Ports
//     clk_i, rstn_i       clock, asynchronous active-low reset
//     clr_stat_i          clears status bits 4:0 (a coincident set wins)
//     timeout_i           watchdog limit in cycles, 0 disables it
//     req_*               transfer request, latched when req_start_i is
//                         accepted (idle and not busy)
//     busy_o              transfer in progress, falls together with eot_o
//     eot_o               one-cycle end-of-transfer pulse
//     status_o            {3'b0, precnt_used, stop_issued, timeout,
//                          data_err, cmd_err}
//     eng                 command/data engine handshake (master side)
// ---------------------------------------------------------------------------
module sdio_txrx_seq #(
  parameter int BLKNUM_W     = 8,
  parameter int TIMEOUT_W    = 24,
  parameter bit AUTO_STOP_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_stat_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 req_start_i,
  input  logic [5:0]           req_op_i,
  input  logic [31:0]          req_arg_i,
  input  logic [2:0]           req_rsp_type_i,
  input  logic                 req_data_en_i,
  input  logic                 req_rwn_i,
  input  logic [BLKNUM_W-1:0]  req_block_num_i,
  input  logic                 req_precount_i,
  output logic                 busy_o,
  output logic                 eot_o,
  output logic [7:0]           status_o,
  sdio_txrx_seq_if.master      eng
);

  localparam logic [5:0] OP_SET_BLOCK_COUNT = 6'd23;
  localparam logic [5:0] OP_STOP            = 6'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECNT,
    ST_MAIN,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  eot_q;
  logic [4:0]            status_q;
  logic                  cmd_start_q;
  logic                  data_start_q;
  logic [5:0]            cmd_op_q;
  logic [31:0]           cmd_arg_q;
  logic [2:0]            cmd_rsp_q;

  // Latched request
  logic [5:0]            op_q;
  logic [31:0]           arg_q;
  logic [2:0]            rsp_q;
  logic                  data_en_q;
  logic                  rwn_q;
  logic [BLKNUM_W-1:0]   blk_q;
  logic                  precnt_q;

  // Per-transfer progress flags
  logic                  cmd_done_q;
  logic                  data_done_q;
  logic                  last_seen_q;
  logic                  data_started_q;
  logic [TIMEOUT_W-1:0]  wd_cnt_q;

  logic                  cmd_done_d;
  logic                  data_done_d;
  logic                  last_seen_d;
  logic [4:0]            stat_set_d;
  logic [4:0]            status_d;
  logic                  in_xfer;
  logic                  wd_reload;
  logic                  wd_expire;
  logic                  accept;
  logic                  use_precnt;
  logic                  stop_needed;
  logic                  stop_go;
  logic                  main_done;
  logic                  data_go;

  always_comb begin
    // Combined "flag already set or setting this cycle" views, so that the
    // decision reacts in the same cycle as the engine event.
    cmd_done_d  = cmd_done_q  | eng.cmd_eot_i;
    data_done_d = data_done_q | eng.data_eot_i;
    last_seen_d = last_seen_q | eng.data_last_i;

    in_xfer   = (state_q == ST_PRECNT) || (state_q == ST_MAIN) ||
                (state_q == ST_STOP);
    wd_reload = eng.cmd_eot_i | eng.data_eot_i | eng.data_last_i;
    // Engine activity in the expiry cycle counts as progress and wins.
    wd_expire = in_xfer && (timeout_i != '0) && !wd_reload &&
                (wd_cnt_q == timeout_i - TIMEOUT_W'(1));

    accept      = (state_q == ST_IDLE) && !busy_q && req_start_i;
    use_precnt  = req_data_en_i && (req_block_num_i != '0) && req_precount_i;
    stop_needed = data_en_q && (blk_q != '0) && !precnt_q && AUTO_STOP_EN;

    stop_go   = (state_q == ST_MAIN) && !wd_expire && stop_needed &&
                last_seen_d && cmd_done_d;
    main_done = (state_q == ST_MAIN) && !wd_expire && !stop_needed &&
                cmd_done_d && (data_done_d || !data_en_q);
    data_go   = (state_q == ST_MAIN) && !data_started_q && data_en_q &&
                (rwn_q ? eng.start_read_i : eng.start_write_i);

    stat_set_d    = '0;
    stat_set_d[0] = in_xfer && eng.cmd_eot_i && eng.cmd_err_i;
    stat_set_d[1] = ((state_q == ST_MAIN) || (state_q == ST_STOP)) &&
                    eng.data_eot_i && eng.data_err_i;
    stat_set_d[2] = wd_expire;
    stat_set_d[3] = stop_go;
    stat_set_d[4] = accept && use_precnt;

    status_d = (clr_stat_i ? 5'b0 : status_q) | stat_set_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      eot_q          <= 1'b0;
      status_q       <= '0;
      cmd_start_q    <= 1'b0;
      data_start_q   <= 1'b0;
      cmd_op_q       <= '0;
      cmd_arg_q      <= '0;
      cmd_rsp_q      <= '0;
      op_q           <= '0;
      arg_q          <= '0;
      rsp_q          <= '0;
      data_en_q      <= 1'b0;
      rwn_q          <= 1'b0;
      blk_q          <= '0;
      precnt_q       <= 1'b0;
      cmd_done_q     <= 1'b0;
      data_done_q    <= 1'b0;
      last_seen_q    <= 1'b0;
      data_started_q <= 1'b0;
      wd_cnt_q       <= '0;
    end else begin
      cmd_start_q  <= 1'b0;
      data_start_q <= 1'b0;
      eot_q        <= 1'b0;
      status_q     <= status_d;

      if (data_go) begin
        data_start_q   <= 1'b1;
        data_started_q <= 1'b1;
      end

      if (in_xfer) begin
        wd_cnt_q <= wd_reload ? '0 : wd_cnt_q + TIMEOUT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          // busy_o is held through the eot_o pulse and drops with it.
          if (eot_q) busy_q <= 1'b0;
          if (accept) begin
            busy_q      <= 1'b1;
            op_q        <= req_op_i;
            arg_q       <= req_arg_i;
            rsp_q       <= req_rsp_type_i;
            data_en_q   <= req_data_en_i;
            rwn_q       <= req_rwn_i;
            blk_q       <= req_block_num_i;
            precnt_q    <= use_precnt;
            wd_cnt_q    <= '0;
            cmd_start_q <= 1'b1;
            if (use_precnt) begin
              cmd_op_q  <= OP_SET_BLOCK_COUNT;
              cmd_arg_q <= 32'(req_block_num_i) + 32'd1;
              cmd_rsp_q <= 3'd1;
              state_q   <= ST_PRECNT;
            end else begin
              cmd_op_q  <= req_op_i;
              cmd_arg_q <= req_arg_i;
              cmd_rsp_q <= req_rsp_type_i;
              state_q   <= ST_MAIN;
            end
          end
        end

        ST_PRECNT: begin
          if (wd_expire) begin
            state_q <= ST_DONE;
          end else if (eng.cmd_eot_i) begin
            if (eng.cmd_err_i) begin
              state_q <= ST_DONE;
            end else begin
              cmd_start_q <= 1'b1;
              cmd_op_q    <= op_q;
              cmd_arg_q   <= arg_q;
              cmd_rsp_q   <= rsp_q;
              wd_cnt_q    <= '0;
              state_q     <= ST_MAIN;
            end
          end
        end

        ST_MAIN: begin
          cmd_done_q  <= cmd_done_d;
          data_done_q <= data_done_d;
          last_seen_q <= last_seen_d;
          if (wd_expire) begin
            state_q <= ST_DONE;
          end else if (stop_go) begin
            // cmd_done is reused to track completion of the STOP command.
            cmd_start_q <= 1'b1;
            cmd_op_q    <= OP_STOP;
            cmd_arg_q   <= '0;
            cmd_rsp_q   <= 3'd1;
            cmd_done_q  <= 1'b0;
            wd_cnt_q    <= '0;
            state_q     <= ST_STOP;
          end else if (main_done) begin
            state_q <= ST_DONE;
          end
        end

        ST_STOP: begin
          cmd_done_q  <= cmd_done_d;
          data_done_q <= data_done_d;
          last_seen_q <= last_seen_d;
          if (wd_expire || (cmd_done_d && data_done_d)) begin
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          eot_q          <= 1'b1;
          cmd_done_q     <= 1'b0;
          data_done_q    <= 1'b0;
          last_seen_q    <= 1'b0;
          data_started_q <= 1'b0;
          state_q        <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o             = busy_q;
  assign eot_o              = eot_q;
  assign status_o           = {3'b000, status_q};
  assign eng.cmd_start_o    = cmd_start_q;
  assign eng.cmd_op_o       = cmd_op_q;
  assign eng.cmd_arg_o      = cmd_arg_q;
  assign eng.cmd_rsp_type_o = cmd_rsp_q;
  assign eng.data_start_o   = data_start_q;

endmodule

// File: tb/tb_sdio_txrx_seq.sv
// ---------------------------------------------------------------------------
// tb_sdio_txrx_seq
//   Bench for sdio_txrx_seq. A table of transfers is played through a small
//   engine responder; expected commands and end-of-transfer status words are
//   queued when a request is driven and popped whenever the DUT pulses
//   cmd_start_o or eot_o. Hand-written sequences cover the watchdog, a
//   request while busy with an early data_last_i, and reset mid-transfer.
// ---------------------------------------------------------------------------
module tb_sdio_txrx_seq;
  localparam int BLKNUM_W  = 8;
  localparam int TIMEOUT_W = 24;

  logic                 clk = 1'b0;
  logic                 rstn_i;
  logic                 clr_stat_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 req_start_i;
  logic [5:0]           req_op_i;
  logic [31:0]          req_arg_i;
  logic [2:0]           req_rsp_type_i;
  logic                 req_data_en_i;
  logic                 req_rwn_i;
  logic [BLKNUM_W-1:0]  req_block_num_i;
  logic                 req_precount_i;
  logic                 busy_o;
  logic                 eot_o;
  logic [7:0]           status_o;

  sdio_txrx_seq_if bus ();

  sdio_txrx_seq #(
    .BLKNUM_W     (BLKNUM_W),
    .TIMEOUT_W    (TIMEOUT_W),
    .AUTO_STOP_EN (1'b1)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .clr_stat_i      (clr_stat_i),
    .timeout_i       (timeout_i),
    .req_start_i     (req_start_i),
    .req_op_i        (req_op_i),
    .req_arg_i       (req_arg_i),
    .req_rsp_type_i  (req_rsp_type_i),
    .req_data_en_i   (req_data_en_i),
    .req_rwn_i       (req_rwn_i),
    .req_block_num_i (req_block_num_i),
    .req_precount_i  (req_precount_i),
    .busy_o          (busy_o),
    .eot_o           (eot_o),
    .status_o        (status_o),
    .eng             (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp;
  } cmd_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp;
    logic        data_en;
    logic        rwn;
    logic [7:0]  blk;
    logic        pc;
    logic        c23err;
    logic        derr;
    logic [7:0]  est;
    logic [1:0]  ncmd;
    cmd_t        e0;
    cmd_t        e1;
  } vec_t;

  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_st_q[$];
  vec_t       tbl[10];

  int   total = 0;
  int   bad   = 0;
  int   n_cmd = 0;
  int   n_dstart = 0;
  logic saw_cmd, saw_data, saw_eot;

  function automatic cmd_t mc(input logic [5:0] op, input logic [31:0] arg,
                              input logic [2:0] rsp);
    cmd_t c;
    c.op = op; c.arg = arg; c.rsp = rsp;
    return c;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] arg,
                              input logic [2:0] rsp, input logic den,
                              input logic rwn, input logic [7:0] blk,
                              input logic pc, input logic c23err,
                              input logic derr, input logic [7:0] est,
                              input logic [1:0] ncmd, input cmd_t e0,
                              input cmd_t e1);
    vec_t v;
    v.op = op; v.arg = arg; v.rsp = rsp; v.data_en = den; v.rwn = rwn;
    v.blk = blk; v.pc = pc; v.c23err = c23err; v.derr = derr; v.est = est;
    v.ncmd = ncmd; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any command/eot pulse.
  task automatic step();
    cmd_t o;
    cmd_t e;
    logic [7:0] es;
    @(negedge clk);
    saw_cmd  = bus.cmd_start_o;
    saw_data = bus.data_start_o;
    saw_eot  = eot_o;
    if (saw_data) n_dstart++;
    if (saw_cmd) begin
      n_cmd++;
      o = mc(bus.cmd_op_o, bus.cmd_arg_o, bus.cmd_rsp_type_o);
      if (exp_cmd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_cmd: got op=%0d arg=%0h expected no command", o.op, o.arg);
      end else begin
        e = exp_cmd_q.pop_front();
        check("cmd_fields", 64'(o), 64'(e));
      end
    end
    if (saw_eot) begin
      if (exp_st_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_eot: got status=%0h expected no eot", status_o);
      end else begin
        es = exp_st_q.pop_front();
        check("eot_status", 64'(status_o), 64'(es));
      end
    end
  endtask

  task automatic pulse_clr();
    clr_stat_i = 1'b1; step(); clr_stat_i = 1'b0;
    check("clr_status", 64'(status_o), 64'h0);
  endtask

  // Called right after the step that ended the final qualifying eot input.
  task automatic check_end();
    step();
    check("eot_lat", 64'(saw_eot), 64'h1);
    check("busy_hold", 64'(busy_o), 64'h1);
    step();
    check("busy_fall", 64'(busy_o), 64'h0);
    check("eot_fall", 64'(eot_o), 64'h0);
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [31:0] arg,
                           input logic [2:0] rsp, input logic den,
                           input logic rwn, input logic [7:0] blk,
                           input logic pc);
    req_op_i = op; req_arg_i = arg; req_rsp_type_i = rsp;
    req_data_en_i = den; req_rwn_i = rwn; req_block_num_i = blk;
    req_precount_i = pc;
    req_start_i = 1'b1; step(); req_start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   nc0, nd0;
    logic pc_path;
    pc_path = v.data_en && (v.blk != 8'd0) && v.pc;
    pulse_clr();
    exp_cmd_q.push_back(v.e0);
    if (v.ncmd > 2'd1) exp_cmd_q.push_back(v.e1);
    exp_st_q.push_back(v.est);
    nc0 = n_cmd; nd0 = n_dstart;
    drive_req(v.op, v.arg, v.rsp, v.data_en, v.rwn, v.blk, v.pc);
    check("start_lat", 64'(saw_cmd), 64'h1);
    check("busy_rise", 64'(busy_o), 64'h1);
    if (pc_path) begin
      step(); step();
      bus.cmd_eot_i = 1'b1; bus.cmd_err_i = v.c23err; step();
      bus.cmd_eot_i = 1'b0; bus.cmd_err_i = 1'b0;
      if (!v.c23err) check("main_lat", 64'(saw_cmd), 64'h1);
    end
    if (!(pc_path && v.c23err)) begin
      step(); step();
      bus.cmd_eot_i = 1'b1;
      if (v.data_en) begin
        if (v.rwn) bus.start_read_i = 1'b1; else bus.start_write_i = 1'b1;
      end
      step();
      bus.cmd_eot_i = 1'b0; bus.start_read_i = 1'b0; bus.start_write_i = 1'b0;
      if (v.data_en) begin
        check("dstart_lat", 64'(saw_data), 64'h1);
        step(); step();
        if (v.blk != 8'd0) begin
          bus.data_last_i = 1'b1; step(); bus.data_last_i = 1'b0;
          check("stop_lat", 64'(saw_cmd), 64'(!v.pc));
          if (!v.pc) begin
            step(); step();
            bus.cmd_eot_i = 1'b1; step(); bus.cmd_eot_i = 1'b0;
            step();
            check("wait_data", 64'(saw_eot), 64'h0);
          end
          step();
        end
        bus.data_eot_i = 1'b1; bus.data_err_i = v.derr; step();
        bus.data_eot_i = 1'b0; bus.data_err_i = 1'b0;
      end
    end
    check_end();
    check("n_cmd", 64'(n_cmd - nc0), 64'(v.ncmd));
    check("n_dstart", 64'(n_dstart - nd0), 64'(v.data_en && !(pc_path && v.c23err)));
  endtask

  initial begin
    int   nc0;
    int   k;
    logic got;

    rstn_i = 1'b0; clr_stat_i = 1'b0; timeout_i = '0; req_start_i = 1'b0;
    req_op_i = '0; req_arg_i = '0; req_rsp_type_i = '0; req_data_en_i = 1'b0;
    req_rwn_i = 1'b0; req_block_num_i = '0; req_precount_i = 1'b0;
    bus.cmd_eot_i = 1'b0; bus.cmd_err_i = 1'b0; bus.start_read_i = 1'b0;
    bus.start_write_i = 1'b0; bus.data_last_i = 1'b0; bus.data_eot_i = 1'b0;
    bus.data_err_i = 1'b0;

    //              op      arg           rsp den rwn blk   pc c23 derr est    n  e0                        e1
    tbl[0] = mk(6'd17, 32'h1000,     3'd1, 1, 1, 8'd0,   0, 0, 0, 8'h00, 2'd1, mc(17, 32'h1000, 1),     mc(0, 0, 0));
    tbl[1] = mk(6'd25, 32'h2000,     3'd1, 1, 0, 8'd3,   0, 0, 0, 8'h08, 2'd2, mc(25, 32'h2000, 1),     mc(12, 0, 1));
    tbl[2] = mk(6'd18, 32'h3000,     3'd1, 1, 1, 8'd7,   1, 0, 0, 8'h10, 2'd2, mc(23, 32'd8, 1),        mc(18, 32'h3000, 1));
    tbl[3] = mk(6'd18, 32'h3000,     3'd1, 1, 1, 8'd7,   1, 1, 0, 8'h11, 2'd1, mc(23, 32'd8, 1),        mc(0, 0, 0));
    tbl[4] = mk(6'd0,  32'h0,        3'd0, 0, 0, 8'd0,   0, 0, 0, 8'h00, 2'd1, mc(0, 0, 0),             mc(0, 0, 0));
    tbl[5] = mk(6'd17, 32'h40,       3'd2, 1, 1, 8'd0,   1, 0, 0, 8'h00, 2'd1, mc(17, 32'h40, 2),       mc(0, 0, 0));
    tbl[6] = mk(6'd7,  32'hDEADBEEF, 3'd5, 0, 0, 8'd5,   1, 0, 0, 8'h00, 2'd1, mc(7, 32'hDEADBEEF, 5),  mc(0, 0, 0));
    tbl[7] = mk(6'd18, 32'h77,       3'd1, 1, 1, 8'd1,   0, 0, 0, 8'h08, 2'd2, mc(18, 32'h77, 1),       mc(12, 0, 1));
    tbl[8] = mk(6'd25, 32'h88,       3'd1, 1, 0, 8'd255, 1, 0, 0, 8'h10, 2'd2, mc(23, 32'd256, 1),      mc(25, 32'h88, 1));
    tbl[9] = mk(6'd24, 32'h99,       3'd1, 1, 0, 8'd0,   0, 0, 1, 8'h02, 2'd1, mc(24, 32'h99, 1),       mc(0, 0, 0));

    // Reset state
    step(); step();
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_eot", 64'(eot_o), 64'h0);
    check("rst_status", 64'(status_o), 64'h0);
    check("rst_cmd_start", 64'(bus.cmd_start_o), 64'h0);
    check("rst_data_start", 64'(bus.data_start_o), 64'h0);
    check("rst_cmd_fields", 64'({bus.cmd_op_o, bus.cmd_arg_o, bus.cmd_rsp_type_o}), 64'h0);
    rstn_i = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Watchdog: data phase never completes, timeout_i = 100
    pulse_clr();
    timeout_i = 24'd100;
    exp_cmd_q.push_back(mc(17, 32'h55, 1));
    exp_st_q.push_back(8'h04);
    drive_req(6'd17, 32'h55, 3'd1, 1'b1, 1'b1, 8'd0, 1'b0);
    check("wd_start", 64'(saw_cmd), 64'h1);
    step(); step();
    bus.cmd_eot_i = 1'b1; bus.start_read_i = 1'b1; step();
    bus.cmd_eot_i = 1'b0; bus.start_read_i = 1'b0;
    k = 1; got = 1'b0;
    while (k < 300 && !got) begin
      step(); k++;
      if (saw_eot) got = 1'b1;
    end
    check("wd_eot_cycle", 64'(k), 64'd102);
    step();
    check("wd_busy_fall", 64'(busy_o), 64'h0);
    pulse_clr();
    timeout_i = '0;

    // data_last_i before main cmd_eot_i, plus a request while busy
    nc0 = n_cmd;
    exp_cmd_q.push_back(mc(25, 32'hABC, 1));
    exp_cmd_q.push_back(mc(12, 32'h0, 1));
    exp_st_q.push_back(8'h08);
    drive_req(6'd25, 32'hABC, 3'd1, 1'b1, 1'b0, 8'd2, 1'b0);
    drive_req(6'd9, 32'h999, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    check("busy_ignore", 64'(saw_cmd), 64'h0);
    bus.data_last_i = 1'b1; step(); bus.data_last_i = 1'b0;
    check("stop_deferred", 64'(saw_cmd), 64'h0);
    step();
    bus.cmd_eot_i = 1'b1; bus.start_write_i = 1'b1; step();
    bus.cmd_eot_i = 1'b0; bus.start_write_i = 1'b0;
    check("stop_after_eot", 64'(saw_cmd), 64'h1);
    check("early_dstart", 64'(saw_data), 64'h1);
    step(); step();
    bus.cmd_eot_i = 1'b1; step(); bus.cmd_eot_i = 1'b0;
    step();
    bus.data_eot_i = 1'b1; step(); bus.data_eot_i = 1'b0;
    check_end();
    check("early_n_cmd", 64'(n_cmd - nc0), 64'd2);
    pulse_clr();

    // Reset in the middle of a transfer: no eot_o afterwards
    exp_cmd_q.push_back(mc(17, 32'h123, 1));
    drive_req(6'd17, 32'h123, 3'd1, 1'b1, 1'b1, 8'd0, 1'b0);
    check("rst_mid_start", 64'(saw_cmd), 64'h1);
    step();
    rstn_i = 1'b0;
    step();
    check("rst_mid_busy", 64'(busy_o), 64'h0);
    check("rst_mid_op", 64'(bus.cmd_op_o), 64'h0);
    rstn_i = 1'b1;
    got = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (saw_eot) got = 1'b1;
    end
    check("rst_mid_no_eot", 64'(got), 64'h0);

    check("cmd_q_empty", 64'(exp_cmd_q.size()), 64'h0);
    check("st_q_empty", 64'(exp_st_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
